// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined N-bit adder/subtractor built from 4-bit CLA groups.
// Each of the L = N/(4*GPS) stages resolves GPS groups, registering the partial sum,
// the group carry and the operand bits still to be consumed. A single global stall
// (adv) freezes every stage when the result register is full and not being taken.
// Optional feature: define CLA_SAT_EN for signed saturation of the result
// (ovf and c_out still report the raw, unsaturated result).
module cla_pipe_addsub #(
   parameter int N   = 16,
   parameter int GPS = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   input  logic         c_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         c_out,
   output logic         ovf,
   output logic         zero
);

   localparam int GW = 4 * GPS;   // bits resolved per stage
   localparam int L  = N / GW;    // pipeline depth / latency

   if ((N % GW) != 0 || N < GW) begin : g_bad_width
      $error("cla_pipe_addsub: N (%0d) must be a non-zero multiple of 4*GPS (%0d)", N, GW);
   end

   // 4-bit carry-lookahead group: returns {group_g, group_p, carry_into_bit3, sum[3:0]}
   function automatic logic [6:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
      logic [3:0] g, p, c;
      logic       gg, pg;
      g    = x & y;
      p    = x ^ y;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      pg   = &p;
      return {gg, pg, c[3], p ^ c};
   endfunction

   // One stage worth of groups: returns {carry_out, carry_into_top_bit, sum[GW-1:0]}.
   // Group carries come from each group's G/P, so no bit-level ripple crosses a group.
   function automatic logic [GW+1:0] stage_add(input logic [GW-1:0] x, input logic [GW-1:0] y,
                                               input logic ci);
      logic [GPS:0]  gc;
      logic [GW-1:0] s;
      logic          cm;
      logic [6:0]    r4;
      gc    = '0;
      s     = '0;
      cm    = 1'b0;
      r4    = '0;
      gc[0] = ci;
      for (int j = 0; j < GPS; j++) begin
         r4         = cla4(x[4*j +: 4], y[4*j +: 4], gc[j]);
         s[4*j +: 4] = r4[3:0];
         cm         = r4[4];
         gc[j+1]    = r4[6] | (r4[5] & gc[j]);
      end
      return {gc[GPS], cm, s};
   endfunction

`ifdef CLA_SAT_EN
   // Clamp to the signed extreme in the direction of operand A's sign on overflow
   function automatic logic [N-1:0] sat_sum(input logic [N-1:0] raw, input logic of,
                                            input logic a_msb);
      logic [N-1:0] r;
      r = raw;
      if (of) begin
         r = a_msb ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end
      return r;
   endfunction
`endif

   // Global advance: the whole pipe moves unless a finished result is waiting
   logic adv;

   // Stage registers; index k holds the state registered at the end of stage k.
   // Element L-1 of the data arrays is never used: stage L-1 writes the output ports.
   logic         vld_p [0:L-1];
   logic [N-1:0] a_p   [0:L-1];
   logic [N-1:0] b_p   [0:L-1];
   logic [N-1:0] s_p   [0:L-1];
   logic         c_p   [0:L-1];

   // Inputs seen by each stage (stage 0: ports, stage k: registers of stage k-1)
   logic         src_v [0:L-1];
   logic [N-1:0] src_a [0:L-1];
   logic [N-1:0] src_b [0:L-1];
   logic [N-1:0] src_s [0:L-1];
   logic         src_c [0:L-1];

   // Combinational results of each stage
   logic [N-1:0] nx_s  [0:L-1];
   logic         nx_c  [0:L-1];
   logic         nx_m  [0:L-1];

   logic [N-1:0] sum_fin;
   logic         ovf_fin;

   assign adv       = !vld_p[L-1] || out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_p[L-1];

   // Route each stage's operands: subtraction folds into an inverted B with carry-in 1
   always_comb begin
      src_v[0] = in_valid;
      src_a[0] = a;
      src_b[0] = sub ? ~b : b;
      src_c[0] = sub | c_in;
      src_s[0] = '0;
      for (int k = 1; k < L; k++) begin
         src_v[k] = vld_p[k-1];
         src_a[k] = a_p[k-1];
         src_b[k] = b_p[k-1];
         src_c[k] = c_p[k-1];
         src_s[k] = s_p[k-1];
      end
   end

   // Resolve this stage's slice of groups and merge it into the running sum
   always_comb begin
      logic [GW+1:0] r;
      r = '0;
      for (int k = 0; k < L; k++) begin
         r                   = stage_add(src_a[k][k*GW +: GW], src_b[k][k*GW +: GW], src_c[k]);
         nx_s[k]             = src_s[k];
         nx_s[k][k*GW +: GW] = r[GW-1:0];
         nx_c[k]             = r[GW+1];
         nx_m[k]             = r[GW];
      end
   end

   assign ovf_fin = nx_m[L-1] ^ nx_c[L-1];

   // Final result shaping: optional saturation, evaluated before the zero flag
   always_comb begin
`ifdef CLA_SAT_EN
      sum_fin = sat_sum(nx_s[L-1], ovf_fin, src_a[L-1][N-1]);
`else
      sum_fin = nx_s[L-1];
`endif
   end

   // ---- stage boundary: valid bits (control, reset) ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < L; k++) vld_p[k] <= 1'b0;
      end else if (adv) begin
         vld_p[0] <= in_valid;
         for (int k = 1; k < L; k++) vld_p[k] <= vld_p[k-1];
      end
   end

   // ---- stage boundary: intermediate data, loaded only for valid ops ----
   always_ff @(posedge clk) begin
      for (int k = 0; k < L - 1; k++) begin
         if (adv && src_v[k]) begin
            a_p[k] <= src_a[k];
            b_p[k] <= src_b[k];
            s_p[k] <= nx_s[k];
            c_p[k] <= nx_c[k];
         end
      end
   end

   // ---- stage boundary: output registers, cleared by reset ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum   <= '0;
         c_out <= 1'b0;
         ovf   <= 1'b0;
         zero  <= 1'b0;
      end else if (adv && src_v[L-1]) begin
         sum   <= sum_fin;
         c_out <= nx_c[L-1];
         ovf   <= ovf_fin;
         zero  <= (sum_fin == '0);
      end
   end

endmodule
